// File: rtl/psc_trigger_conditioner_pkg.sv
// Shared definitions for the power-supply controller trigger path:
// FSM state encoding and default filter / hold-off lengths.
package psc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_FIRE     = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_WAIT_LOW = 3'd4
  } psc_state_e;

  localparam int unsigned PSC_DEF_FILTER_LEN  = 4;
  localparam int unsigned PSC_DEF_HOLDOFF_LEN = 16;

endpackage

// File: rtl/psc_trigger_conditioner_if.sv
// Trigger conditioner bundle: raw trigger/enable in, conditioned pulse,
// busy flag and statistics counters out.
interface psc_trigger_conditioner_if #(
  parameter int unsigned CNT_W = 16
);
  logic             trig_in;
  logic             enable;
  logic             trigger_pulse;
  logic             busy;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] missed_count;
  logic [CNT_W-1:0] glitch_count;

  modport master (
    output trig_in, enable,
    input  trigger_pulse, busy, trig_count, missed_count, glitch_count
  );

  modport slave (
    input  trig_in, enable,
    output trigger_pulse, busy, trig_count, missed_count, glitch_count
  );
endinterface

// File: rtl/psc_trigger_conditioner_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs,
// synchronous active-high reset.
module psc_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/psc_trigger_conditioner.sv
// Trigger conditioner: synchronise, glitch-filter, fire one-cycle pulse,
// hold off. Statistics counters present only when PSC_TRIG_STATS_EN is defined.
module psc_trigger_conditioner
  import psc_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = PSC_DEF_FILTER_LEN,
  parameter int unsigned HOLDOFF_LEN = PSC_DEF_HOLDOFF_LEN,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  psc_trigger_conditioner_if.slave bus
);
  localparam logic [7:0]  QUAL_LAST = 8'(FILTER_LEN - 1);
  localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF_LEN - 1);

  logic       s2, s2_d, rise;
  psc_state_e state, state_nxt;
  logic [7:0] qual_cnt, qual_nxt;
  logic [15:0] hold_cnt, hold_nxt;
  logic       trig_ev, missed_ev, glitch_ev;

  psc_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.trig_in),
    .q     (s2)
  );

  assign rise = s2 & ~s2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_d     <= 1'b0;
      state    <= ST_IDLE;
      qual_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      s2_d     <= s2;
      state    <= state_nxt;
      qual_cnt <= qual_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    qual_nxt  = qual_cnt;
    hold_nxt  = hold_cnt;
    trig_ev   = 1'b0;
    missed_ev = 1'b0;
    glitch_ev = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable && s2) begin
          if (FILTER_LEN == 1) begin
            state_nxt = ST_FIRE;
          end else begin
            state_nxt = ST_QUALIFY;
            qual_nxt  = 8'd1;
          end
        end
      end
      ST_QUALIFY: begin
        // A falling input takes priority over enable so it is always counted
        if (!s2) begin
          state_nxt = ST_IDLE;
          glitch_ev = 1'b1;
        end else if (!bus.enable) begin
          state_nxt = ST_IDLE;
        end else if (qual_cnt == QUAL_LAST) begin
          state_nxt = ST_FIRE;
        end else begin
          qual_nxt = qual_cnt + 8'd1;
        end
      end
      ST_FIRE: begin
        trig_ev   = 1'b1;
        hold_nxt  = HOLD_INIT;
        state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        missed_ev = rise;
        if (hold_cnt == 16'd0) begin
          state_nxt = s2 ? ST_WAIT_LOW : ST_IDLE;
        end else begin
          hold_nxt = hold_cnt - 16'd1;
        end
      end
      ST_WAIT_LOW: begin
        if (!s2) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.trigger_pulse = (state == ST_FIRE);
  assign bus.busy          = (state != ST_IDLE);

`ifdef PSC_TRIG_STATS_EN
  logic [CNT_W-1:0] trig_q, missed_q, glitch_q;

  // Saturating counters: hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q   <= '0;
      missed_q <= '0;
      glitch_q <= '0;
    end else begin
      if (trig_ev   && (trig_q   != '1)) trig_q   <= trig_q   + 1'b1;
      if (missed_ev && (missed_q != '1)) missed_q <= missed_q + 1'b1;
      if (glitch_ev && (glitch_q != '1)) glitch_q <= glitch_q + 1'b1;
    end
  end

  assign bus.trig_count   = trig_q;
  assign bus.missed_count = missed_q;
  assign bus.glitch_count = glitch_q;
`else
  logic unused_stats;
  assign unused_stats     = trig_ev ^ missed_ev ^ glitch_ev;
  assign bus.trig_count   = {CNT_W{1'b0}};
  assign bus.missed_count = {CNT_W{1'b0}};
  assign bus.glitch_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_psc_trigger_conditioner.sv
// Directed bench for psc_trigger_conditioner; counter expectations follow
// whether PSC_TRIG_STATS_EN is defined for the build.
module tb_psc_trigger_conditioner;
  import psc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef PSC_TRIG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  psc_trigger_conditioner_if #(.CNT_W(16)) bus ();
  psc_trigger_conditioner_if #(.CNT_W(2))  bus_s ();

  assign bus_s.trig_in = bus.trig_in;
  assign bus_s.enable  = bus.enable;

  psc_trigger_conditioner #(.FILTER_LEN(4), .HOLDOFF_LEN(16), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  psc_trigger_conditioner #(.FILTER_LEN(4), .HOLDOFF_LEN(16), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  function automatic int unsigned stat(input int unsigned n);
    return STATS ? n : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_counts(input string tag, input int unsigned t, input int unsigned m,
                            input int unsigned g);
    chk({tag, "_trig"},   32'(bus.trig_count),   32'(stat(t)));
    chk({tag, "_missed"}, 32'(bus.missed_count), 32'(stat(m)));
    chk({tag, "_glitch"}, 32'(bus.glitch_count), 32'(stat(g)));
  endtask

  initial begin
    reset       = 1'b1;
    bus.trig_in = 1'b0;
    bus.enable  = 1'b1;
    tick();
    tick();
    chk("rst_pulse", 32'(bus.trigger_pulse), 32'd0);
    chk("rst_busy",  32'(bus.busy),          32'd0);
    chk_counts("rst", 0, 0, 0);
    reset = 1'b0;

    // Long pulse: one fire after edge 6, hold-off ends with the input fall
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 20) bus.trig_in = 1'b0;
      chk($sformatf("s1_pulse_%0d", i), 32'(bus.trigger_pulse), 32'(i == 6));
      chk($sformatf("s1_busy_%0d", i),  32'(bus.busy),          32'(i >= 3 && i <= 22));
    end
    chk_counts("s1", 1, 0, 0);

    // Three-sample glitch
    do_reset();
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) bus.trig_in = 1'b0;
      chk($sformatf("s2_pulse_%0d", i), 32'(bus.trigger_pulse), 32'd0);
      chk($sformatf("s2_busy_%0d", i),  32'(bus.busy),          32'(i >= 3 && i <= 5));
    end
    chk_counts("s2", 0, 0, 1);

    // Edge inside hold-off is dropped; a later edge fires normally
    do_reset();
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 4)  bus.trig_in = 1'b0;
      if (i == 8)  bus.trig_in = 1'b1;
      if (i == 10) bus.trig_in = 1'b0;
      if (i == 25) bus.trig_in = 1'b1;
      chk($sformatf("s3_pulse_%0d", i), 32'(bus.trigger_pulse), 32'(i == 6 || i == 31));
      chk($sformatf("s3_busy_%0d", i),  32'(bus.busy),
          32'((i >= 3 && i <= 22) || i >= 28));
    end
    chk_counts("s3", 2, 1, 0);
    bus.trig_in = 1'b0;
    repeat (15) tick();
    chk("s3_busy_end_hi", 32'(bus.busy), 32'd1);
    tick();
    chk("s3_busy_end_lo", 32'(bus.busy), 32'd0);

    // Enable dropped during qualification
    do_reset();
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) bus.enable = 1'b0;
      chk($sformatf("s4a_pulse_%0d", i), 32'(bus.trigger_pulse), 32'd0);
      chk($sformatf("s4a_busy_%0d", i),  32'(bus.busy),          32'(i == 3));
    end
    chk_counts("s4a", 0, 0, 0);
    bus.trig_in = 1'b0;
    repeat (4) tick();
    bus.enable = 1'b1;
    repeat (2) tick();

    // Enable dropped during hold-off with input held high: completes, waits for low
    do_reset();
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 8)  bus.enable = 1'b0;
      if (i == 30) bus.enable = 1'b1;
      if (i == 40) bus.trig_in = 1'b0;
      chk($sformatf("s4b_pulse_%0d", i), 32'(bus.trigger_pulse), 32'(i == 6));
      chk($sformatf("s4b_busy_%0d", i),  32'(bus.busy),          32'(i >= 3 && i <= 42));
    end
    chk_counts("s4b", 1, 0, 0);

    // Reset on the edge that would enter FIRE
    do_reset();
    bus.trig_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) reset = 1'b1;
      if (i == 6) begin
        reset = 1'b0;
        chk_counts("s5_after_rst", 0, 0, 0);
      end
      chk($sformatf("s5_pulse_%0d", i), 32'(bus.trigger_pulse), 32'd0);
      chk($sformatf("s5_busy_%0d", i),  32'(bus.busy),          32'(i >= 3 && i <= 5));
    end
    bus.trig_in = 1'b0;
    repeat (4) tick();

    // Counter saturation on the 2-bit instance
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      bus.trig_in = 1'b1;
      repeat (3) tick();
      bus.trig_in = 1'b0;
      repeat (6) tick();
      if (n == 3) chk("sat_glitch_3", 32'(bus_s.glitch_count), 32'(stat(3)));
    end
    chk("sat_glitch_4",  32'(bus_s.glitch_count), 32'(stat(3)));
    chk("wide_glitch_4", 32'(bus.glitch_count),   32'(stat(4)));
    chk("sat_busy",      32'(bus_s.busy),         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
